// File: rtl/axis_decim_avg.sv
// Multi-channel AXI-Stream decimator: per window of (D+1) beats emit either the last beat (drop)
// or the shifted, saturated sum (average). Optional frame-end marking via `DECIM_TLAST_EN.
module axis_decim_avg #(
    parameter int NUM_CH         = 2,
    parameter int DATA_IN_WIDTH  = 12,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int DATA_REG_WIDTH = 32,
    parameter int ACC_WIDTH      = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic                               mode,
    input  logic [DATA_REG_WIDTH-1:0]          decimate_reg,
    input  logic [4:0]                         shift_reg,
    input  logic [NUM_CH*DATA_IN_WIDTH-1:0]    in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NUM_CH*DATA_OUT_WIDTH-1:0]   out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    input  logic [15:0]                        frame_len
);

    localparam int W_IN  = DATA_IN_WIDTH;
    localparam int W_OUT = DATA_OUT_WIDTH;

    logic [DATA_REG_WIDTH-1:0]      cnt_q, cnt_d;
    logic [DATA_REG_WIDTH-1:0]      d_lat_q, d_lat_d;
    logic [DATA_REG_WIDTH-1:0]      d_cur;
    logic                           out_valid_q, out_valid_d;
    logic [NUM_CH*W_OUT-1:0]        out_data_q, out_data_d;
    logic [NUM_CH*W_OUT-1:0]        avg_data;
    logic [NUM_CH*W_OUT-1:0]        drop_data;
    logic                           accept;
    logic                           win_close;
    logic                           xfer;

    // While disabled the input side is drained so upstream never stalls.
    assign in_ready  = !enable || !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready && enable;
    assign xfer      = out_valid_q && out_ready;
    // The window length is taken live on the first beat and latched for the rest.
    assign d_cur     = (cnt_q == '0) ? decimate_reg : d_lat_q;
    assign win_close = accept && (cnt_q == d_cur);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [W_IN-1:0]      sample;
            logic [ACC_WIDTH-1:0] acc_q, acc_d;
            logic [ACC_WIDTH-1:0] base;
            logic [ACC_WIDTH-1:0] sum;
            logic [ACC_WIDTH-1:0] shifted;

            assign sample  = in_data[gi*W_IN +: W_IN];
            assign base    = (cnt_q == '0) ? '0 : acc_q;
            assign sum     = base + ACC_WIDTH'(sample);
            assign shifted = sum >> shift_reg;

            assign drop_data[gi*W_OUT +: W_OUT] = W_OUT'(sample);

            if (ACC_WIDTH > W_OUT) begin : g_sat
                assign avg_data[gi*W_OUT +: W_OUT] =
                    (|shifted[ACC_WIDTH-1:W_OUT]) ? {W_OUT{1'b1}} : shifted[W_OUT-1:0];
            end else begin : g_nosat
                assign avg_data[gi*W_OUT +: W_OUT] = W_OUT'(shifted);
            end

            // Accumulate regardless of mode so a mode change lands on a valid sum at close.
            always_comb begin
                acc_d = acc_q;
                if (!enable) begin
                    acc_d = '0;
                end else if (accept) begin
                    acc_d = sum;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end
    endgenerate

    always_comb begin
        cnt_d       = cnt_q;
        d_lat_d     = d_lat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (!enable) begin
            cnt_d = '0;
        end else if (accept) begin
            if (cnt_q == '0) begin
                d_lat_d = decimate_reg;
            end
            cnt_d = win_close ? '0 : cnt_q + DATA_REG_WIDTH'(1);
        end

        if (xfer) begin
            out_valid_d = 1'b0;
        end
        // A closing window reloads the register even on the cycle it transfers.
        if (win_close) begin
            out_valid_d = 1'b1;
            out_data_d  = mode ? avg_data : drop_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            d_lat_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            d_lat_q     <= d_lat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef DECIM_TLAST_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [15:0] flen_q, flen_d;
    logic [15:0] flen_eff;

    // Frame length is re-sampled only at the start of each frame; zero behaves as one.
    assign flen_eff = (beat_cnt_q == 16'd0) ? ((frame_len == 16'd0) ? 16'd1 : frame_len) : flen_q;
    assign out_last = out_valid_q && (beat_cnt_q == flen_eff - 16'd1);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        flen_d     = flen_q;
        if (beat_cnt_q == 16'd0) begin
            flen_d = flen_eff;
        end
        if (!enable) begin
            beat_cnt_d = 16'd0;
        end else if (xfer) begin
            beat_cnt_d = out_last ? 16'd0 : beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q <= 16'd0;
            flen_q     <= 16'd1;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            flen_q     <= flen_d;
        end
    end
`else
    logic unused_frame_len;
    assign unused_frame_len = ^frame_len;
    assign out_last         = 1'b0;
`endif

endmodule

// File: tb/tb_axis_decim_avg.sv
// Directed bench for axis_decim_avg: a scoreboard queue is filled as beats are accepted
// and drained by a monitor on the falling edge; define DECIM_TLAST_EN to cover framing.
module tb_axis_decim_avg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        mode;
    logic [31:0] decim;
    logic [4:0]  shift;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] frame_len;

    always #5 clk = ~clk;

    axis_decim_avg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .decimate_reg (decim),
        .shift_reg    (shift),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .frame_len    (frame_len)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    int          m_cnt  = 0;
    longint      m_dlat = 0;
    longint      m_acc[2];
    int          n_out  = 0;
    int          n_last = 0;
    int          tcnt   = 0;
    logic [31:0] held;
    logic        held_v = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer sums without wrap, shift and clamp to 16 bits.
    task automatic model_accept(input logic [11:0] a, input logic [11:0] b);
        longint s[2];
        longint v;
        logic [15:0] e[2];
        s[0] = a;
        s[1] = b;
        if (m_cnt == 0) m_dlat = decim;
        for (int k = 0; k < 2; k++) m_acc[k] = ((m_cnt == 0) ? 0 : m_acc[k]) + s[k];
        if (m_cnt == m_dlat) begin
            for (int k = 0; k < 2; k++) begin
                if (!mode) begin
                    e[k] = 16'(s[k]);
                end else begin
                    v    = m_acc[k] >> shift;
                    e[k] = (v > 65535) ? 16'hFFFF : 16'(v);
                end
            end
            exp_q.push_back({e[1], e[0]});
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        in_data  = {b, a};
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            chk("send_timeout", 64'(guard), 64'(0));
        end else begin
            model_accept(a, b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
    endtask

    always @(negedge clk) begin
        logic exp_last;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
`ifdef DECIM_TLAST_EN
            exp_last = (tcnt == int'(frame_len) - 1);
            tcnt     = exp_last ? 0 : tcnt + 1;
`else
            exp_last = 1'b0;
`endif
            if (out_last) n_last++;
            chk("out_last", 64'(out_last), 64'(exp_last));
            chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                $display("out beat %0d: ch0=%0d ch1=%0d last=%0b", n_out, out_data[15:0], out_data[31:16], out_last);
            end
        end
        if (rst_n && held_v && out_valid) chk("stall_hold", 64'(out_data), 64'(held));
        held_v = rst_n && out_valid && !out_ready;
        held   = out_data;
    end

    initial begin
        int base_out;
        int base_last;
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; decim = 32'd3; shift = 5'd0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1; frame_len = 16'd3;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1; enable = 1'b1;

        // Drop mode ramp, D=3
        base_out = n_out;
        for (int i = 0; i < 12; i++) send(12'(i), 12'(100 + i));
        drain();
        chk("drop_count", 64'(n_out - base_out), 64'(3));

        // Average mode: constant full-scale, then saturation at D=31
        mode = 1'b1; shift = 5'd2; decim = 32'd3;
        for (int i = 0; i < 8; i++) send(12'd4095, 12'(i * 7));
        drain();
        shift = 5'd0; decim = 32'd31;
        for (int i = 0; i < 32; i++) send(12'd4095, 12'd10);
        drain();

        // Backpressure at D=0
        mode = 1'b0; decim = 32'd0;
        base_out = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send(12'(200 + i), 12'(300 + i));
            end
            begin
                @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) @(negedge clk);
                chk("in_ready_stall", 64'(in_ready), 64'(0));
                repeat (2) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(n_out - base_out), 64'(6));

        // Window length changed mid-window
        decim = 32'd3;
        base_out = n_out;
        send(12'd1, 12'd2);
        send(12'd3, 12'd4);
        decim = 32'd1;
        for (int i = 0; i < 6; i++) send(12'(10 + i), 12'(20 + i));
        drain();
        chk("midwin_count", 64'(n_out - base_out), 64'(3));

        // Enable dropped mid-window, partial sum discarded
        mode = 1'b1; shift = 5'd0; decim = 32'd3;
        send(12'd1000, 12'd1000);
        send(12'd1000, 12'd1000);
        @(negedge clk);
        enable = 1'b0; in_valid = 1'b1; in_data = {12'd777, 12'd777};
        m_cnt = 0; tcnt = 0;
        repeat (3) begin
            @(negedge clk);
            chk("dis_in_ready", 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0; enable = 1'b1;
        base_out = n_out;
        for (int i = 1; i <= 4; i++) send(12'(10 * i), 12'(i));
        drain();
        chk("enable_count", 64'(n_out - base_out), 64'(1));

`ifdef DECIM_TLAST_EN
        mode = 1'b0; decim = 32'd0; frame_len = 16'd3;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; tcnt = 0;
        base_last = n_last;
        for (int i = 0; i < 9; i++) send(12'(i), 12'(i));
        drain();
        chk("last_count", 64'(n_last - base_last), 64'(3));
        send(12'd50, 12'd51);
        send(12'd52, 12'd53);
        drain();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; tcnt = 0; m_cnt = 0;
        base_last = n_last;
        for (int i = 0; i < 3; i++) send(12'(60 + i), 12'(70 + i));
        drain();
        chk("last_after_rst", 64'(n_last - base_last), 64'(1));
`else
        base_last = n_last;
        chk("no_last", 64'(n_last - base_last), 64'(0));
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_decim_avg.md
Name: axis_decim_avg

Overview:
- Parametrised multi-channel decimator for the ADC streaming path. Sits between the ADC capture front end and the AXI-Stream DMA/packer.
- Accepts one beat per cycle carrying NUM_CH packed samples. Emits one beat per (decimate_reg+1) accepted input beats.
- Two modes: drop (keep the last sample of each window) and average (sum the window, right-shift, saturate).
- Full ready/valid backpressure on both sides. Input is never silently lost while enabled.

Parameters:
- NUM_CH, 2, number of channels packed per beat (1..8).
- DATA_IN_WIDTH, 12, unsigned sample width per channel.
- DATA_OUT_WIDTH, 16, output sample width per channel (must be >= DATA_IN_WIDTH).
- DATA_REG_WIDTH, 32, width of decimate_reg.
- ACC_WIDTH, 32, per-channel accumulator width (must be >= DATA_IN_WIDTH+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  1 = run; 0 = flush window, discard input
- mode  in  1  0 = drop, 1 = average
- decimate_reg  in  DATA_REG_WIDTH  window length minus one (D)
- shift_reg  in  5  average-mode right shift applied to the sum
- in_data  in  NUM_CH*DATA_IN_WIDTH  channel k at bits [k*W_IN +: W_IN]
- in_valid  in  1  input valid
- in_ready  out  1  input ready
- out_data  out  NUM_CH*DATA_OUT_WIDTH  channel k at bits [k*W_OUT +: W_OUT]
- out_valid  out  1  output valid
- out_ready  in  1  output ready
- out_last  out  1  frame end (only with the optional feature; otherwise tied 0)
- frame_len  in  16  beats per frame (only with the optional feature)

Behaviour:
- Reset and clock: clk, rst_n synchronous active-low. Reset is sampled on the clk edge.
- Reset values: out_valid=0, out_data=0, out_last=0, cnt=0, all accumulators=0, frame counter=0. in_ready is combinational, so it equals 1 in reset-exit state.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Input beat accepted when in_valid && in_ready && enable.
  - Output beat transfers when out_valid && out_ready.
  - out_data is stable while out_valid && !out_ready.
- Window latch: D_lat is captured from decimate_reg on the first accepted beat of each window (cnt==0). Changes to decimate_reg mid-window take effect next window.
- Accepted beat, cnt != D_lat: cnt++. In average mode, acc[k] += sample[k], with acc[k] := sample[k] when cnt==0.
- Accepted beat, cnt == D_lat (window close): cnt := 0, out_valid := 1 on the next edge (latency 1 cycle from the closing beat).
  - Drop mode: out_data[k] = zero-extended sample[k] of the closing beat.
  - Average mode: s = (acc[k] + sample[k]) >> shift_reg. out_data[k] = s if s < 2^W_OUT, else 2^W_OUT-1.
- Mode latching: mode and shift_reg are sampled at window close.
- Output register: out_valid drops on transfer unless a new window closes the same cycle, which reloads it (back-to-back output at D=0).
- D=0: every accepted beat produces an output. Average mode then outputs sample >> shift_reg.
- Accumulator overflow: wraps modulo 2^ACC_WIDTH. The user must choose D so that (D+1)*(2^W_IN-1) < 2^ACC_WIDTH.
- enable=0:
  - cnt and acc are cleared; the partial window is discarded.
  - in_ready is forced 1 and input is dropped.
  - A pending out_valid beat is held until consumed.
- Reset mid-operation: all state returns to reset values on the next edge. A pending output beat is lost.

Optional Feature:
- Macro: DECIM_TLAST_EN.
- Defined:
  - A 16-bit output-beat counter counts transferred beats.
  - out_last=1 on the beat where count == frame_len-1; the counter then wraps to 0.
  - frame_len is sampled when the counter is 0. frame_len=0 is treated as 1.
  - enable=0 clears the counter.
- Undefined: the counter is absent, out_last is constant 0, and frame_len is unused.

Test Plan:
- Drop mode, NUM_CH=2, D=3, out_ready=1, in ramp ch0=0,1,2,... ch1=100,101,... → outputs ch0=3,7,11; ch1=103,107,111; one out_valid pulse every 4 accepted beats.
- Average mode, D=3, shift=2, ch0 constant 4095 → out 4095. Shift=0 with D=31 → sum 131040 saturates to 65535.
- Backpressure: D=0, out_ready low 5 cycles → in_ready low after first beat, out_data held stable, no beats lost or duplicated on release (compare against a reference queue).
- Mid-window change: D=3→1 written after 2 beats of a window → current window closes at 4 beats, following windows at 2.
- enable dropped after 2 beats of a D=3 window, then raised → first output after 4 fresh beats; discarded samples are absent from the sum.
- DECIM_TLAST_EN, frame_len=3, D=0 → out_last asserted on output beats 3,6,9; rst_n low mid-frame → counter restarts, next out_last on the 3rd beat after reset.
